// File: rtl/j2_pkg.sv
// Shared j2 core definitions: stack operation encoding used by the stacks and the core ALU.
package j2_pkg;

  typedef logic [1:0] stack_op_t;

  localparam stack_op_t STACK_OP_HOLD  = 2'b00;
  localparam stack_op_t STACK_OP_PUSH  = 2'b01;
  localparam stack_op_t STACK_OP_POP   = 2'b10;
  localparam stack_op_t STACK_OP_DROP2 = 2'b11;

endpackage

// File: rtl/cached_stack_ram.sv
// Stack body storage: one synchronous write port and three asynchronous read ports.
// Contents are deliberately left unreset; only the stack pointer state is reset.
module stack_ram #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clock,
  input  logic                  write_enable,
  input  logic [DEPTH_LOG2-1:0] write_addr,
  input  logic [WIDTH-1:0]      write_data,
  input  logic [DEPTH_LOG2-1:0] read_addr_a,
  output logic [WIDTH-1:0]      read_data_a,
  input  logic [DEPTH_LOG2-1:0] read_addr_b,
  output logic [WIDTH-1:0]      read_data_b,
  input  logic [DEPTH_LOG2-1:0] read_addr_c,
  output logic [WIDTH-1:0]      read_data_c
);

  localparam int N = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0] mem [N];

  always_ff @(posedge clock) begin
    if (write_enable) begin
      mem[write_addr] <= write_data;
    end
  end

  assign read_data_a = mem[read_addr_a];
  assign read_data_b = mem[read_addr_b];
  assign read_data_c = mem[read_addr_c];

endmodule

// File: rtl/cached_stack.sv
// j2 data/return stack: registered TOS, body in stack_ram, occupancy count,
// sticky overflow/underflow flags and a debug peek port.
module cached_stack
  import j2_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 5,
  parameter bit WRAP       = 1'b1
) (
  input  logic                  clock,
  input  logic                  active_low_reset,
  input  logic                  op_valid,
  input  logic [1:0]            op,
  input  logic                  write_top,
  input  logic [WIDTH-1:0]      top_in,
  input  logic                  clear_errors,
  input  logic [DEPTH_LOG2-1:0] peek_index,
  output logic [WIDTH-1:0]      top,
  output logic [WIDTH-1:0]      second,
  output logic [WIDTH-1:0]      peek_data,
  output logic                  peek_valid,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_TWO    = DEPTH_LOG2'(2);
  localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   COUNT_TWO  = (DEPTH_LOG2 + 1)'(2);
  localparam logic [DEPTH_LOG2:0]   COUNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DEPTH_LOG2-1:0] ptr;
  logic [DEPTH_LOG2-1:0] ptr_next;
  logic [DEPTH_LOG2:0]   count_next;
  logic [WIDTH-1:0]      top_default;
  logic [WIDTH-1:0]      top_next;
  logic                  push_write;
  logic                  overflow_hit;
  logic                  underflow_hit;
  logic                  allow;
  logic                  execute;
  logic                  ram_write;
  logic [WIDTH-1:0]      body_ptr;
  logic [WIDTH-1:0]      body_ptr_less1;

  stack_op_t stack_op;
  assign stack_op = op;

  // Error detection is independent of WRAP; WRAP only decides whether the op still executes.
  always_comb begin
    overflow_hit  = 1'b0;
    underflow_hit = 1'b0;
    if (op_valid) begin
      case (stack_op)
        STACK_OP_PUSH:  overflow_hit  = (count == COUNT_FULL);
        STACK_OP_POP:   underflow_hit = (count == '0);
        STACK_OP_DROP2: underflow_hit = (count < COUNT_TWO);
        default:        ;
      endcase
    end
  end

  generate
    if (WRAP) begin : g_wrap
      assign allow = 1'b1;
    end else begin : g_reject
      assign allow = !(overflow_hit || underflow_hit);
    end
  endgenerate

  assign execute = op_valid && allow;

  always_comb begin
    ptr_next    = ptr;
    count_next  = count;
    top_default = top;
    push_write  = 1'b0;
    case (stack_op)
      STACK_OP_HOLD: begin
        top_default = top;
      end
      STACK_OP_PUSH: begin
        push_write = 1'b1;
        ptr_next   = ptr + PTR_ONE;
        count_next = (count == COUNT_FULL) ? COUNT_FULL : count + COUNT_ONE;
      end
      STACK_OP_POP: begin
        top_default = body_ptr;
        ptr_next    = ptr - PTR_ONE;
        count_next  = (count == '0) ? '0 : count - COUNT_ONE;
      end
      STACK_OP_DROP2: begin
        top_default = body_ptr_less1;
        ptr_next    = ptr - PTR_TWO;
        count_next  = (count < COUNT_TWO) ? '0 : count - COUNT_TWO;
      end
      default: ;
    endcase
    top_next = write_top ? top_in : top_default;
  end

  // Gating with the reset keeps an op that is in flight when reset asserts from touching the body.
  assign ram_write = execute && push_write && active_low_reset;

  stack_ram #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clock        (clock),
    .write_enable (ram_write),
    .write_addr   (ptr + PTR_ONE),
    .write_data   (top),
    .read_addr_a  (ptr),
    .read_data_a  (body_ptr),
    .read_addr_b  (ptr - PTR_ONE),
    .read_data_b  (body_ptr_less1),
    .read_addr_c  (ptr - peek_index),
    .read_data_c  (peek_data)
  );

  assign second     = body_ptr;
  assign peek_valid = ({1'b0, peek_index} < count);

  always_ff @(posedge clock or negedge active_low_reset) begin
    if (!active_low_reset) begin
      top       <= '0;
      ptr       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (execute) begin
        top   <= top_next;
        ptr   <= ptr_next;
        count <= count_next;
      end
      // A fresh error in the clearing cycle leaves the flag set.
      overflow  <= (overflow && !clear_errors) || overflow_hit;
      underflow <= (underflow && !clear_errors) || underflow_hit;
    end
  end

endmodule

// File: tb/tb_cached_stack.sv
// Directed bench for cached_stack: a large wrapping stack plus two 4-entry stacks
// (wrapping and rejecting) driven with the same op stream.
module tb_cached_stack;
  import j2_pkg::*;

  logic        clock = 1'b0;
  logic        active_low_reset = 1'b1;
  logic        op_valid = 1'b0;
  logic [1:0]  op = STACK_OP_HOLD;
  logic        write_top = 1'b0;
  logic [15:0] top_in = '0;
  logic        clear_errors = 1'b0;
  logic [4:0]  peek_index = '0;

  logic [15:0] b_top, b_second, b_peek_data;
  logic        b_peek_valid, b_ovf, b_unf;
  logic [5:0]  b_count;
  logic [15:0] w_top, w_second, w_peek_data;
  logic        w_peek_valid, w_ovf, w_unf;
  logic [2:0]  w_count;
  logic [15:0] r_top, r_second, r_peek_data;
  logic        r_peek_valid, r_ovf, r_unf;
  logic [2:0]  r_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  cached_stack #(.WIDTH(16), .DEPTH_LOG2(5), .WRAP(1'b1)) u_big (
    .clock(clock), .active_low_reset(active_low_reset), .op_valid(op_valid), .op(op),
    .write_top(write_top), .top_in(top_in), .clear_errors(clear_errors), .peek_index(peek_index),
    .top(b_top), .second(b_second), .peek_data(b_peek_data), .peek_valid(b_peek_valid),
    .count(b_count), .overflow(b_ovf), .underflow(b_unf));

  cached_stack #(.WIDTH(16), .DEPTH_LOG2(2), .WRAP(1'b1)) u_wrap (
    .clock(clock), .active_low_reset(active_low_reset), .op_valid(op_valid), .op(op),
    .write_top(write_top), .top_in(top_in), .clear_errors(clear_errors), .peek_index(peek_index[1:0]),
    .top(w_top), .second(w_second), .peek_data(w_peek_data), .peek_valid(w_peek_valid),
    .count(w_count), .overflow(w_ovf), .underflow(w_unf));

  cached_stack #(.WIDTH(16), .DEPTH_LOG2(2), .WRAP(1'b0)) u_rej (
    .clock(clock), .active_low_reset(active_low_reset), .op_valid(op_valid), .op(op),
    .write_top(write_top), .top_in(top_in), .clear_errors(clear_errors), .peek_index(peek_index[1:0]),
    .top(r_top), .second(r_second), .peek_data(r_peek_data), .peek_valid(r_peek_valid),
    .count(r_count), .overflow(r_ovf), .underflow(r_unf));

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step(input logic [1:0] o, input logic wt, input logic [15:0] v,
                      input logic clr, input logic vld);
    op = o; write_top = wt; top_in = v; clear_errors = clr; op_valid = vld;
    @(posedge clock); #1;
    op_valid = 1'b0; clear_errors = 1'b0; write_top = 1'b0;
  endtask

  task automatic push(input logic [15:0] v);
    step(STACK_OP_PUSH, 1'b1, v, 1'b0, 1'b1);
  endtask

  // Called 1 time unit after a clock edge, so the pulse sits between edges.
  task automatic pulse_reset();
    active_low_reset = 1'b0;
    #1;
    active_low_reset = 1'b1;
  endtask

  initial begin
    // Reset state, and an op presented during reset must be ignored
    #2 active_low_reset = 1'b0;
    #1;
    check("reset_top", b_top, 0);
    check("reset_count", b_count, 0);
    check("reset_flags", {b_ovf, b_unf, r_ovf, r_unf}, 0);
    op = STACK_OP_PUSH; write_top = 1'b1; top_in = 16'h55; op_valid = 1'b1;
    @(posedge clock); #1;
    check("reset_abort_top", b_top, 0);
    check("reset_abort_count", b_count, 0);
    op_valid = 1'b0; write_top = 1'b0;
    active_low_reset = 1'b1;

    // Test 1: three pushes
    push(16'd1); push(16'd2); push(16'd3);
    check("t1_top", b_top, 3);
    check("t1_second", b_second, 2);
    check("t1_count", b_count, 3);
    check("t1_flags", {b_ovf, b_unf}, 0);
    peek_index = 5'd1; #1;
    check("t1_peek1", b_peek_data, 1);
    check("t1_peek1_valid", b_peek_valid, 1);
    peek_index = 5'd2; #1;
    check("t1_peek2", b_peek_data, 0);
    peek_index = 5'd3; #1;
    check("t1_peek3_valid", b_peek_valid, 0);

    // Test 2: pop then drop2 down to empty
    step(STACK_OP_POP, 1'b0, 16'h0, 1'b0, 1'b1);
    check("t2_pop_top", b_top, 2);
    check("t2_pop_count", b_count, 2);
    check("t2_pop_second", b_second, 1);
    step(STACK_OP_DROP2, 1'b0, 16'h0, 1'b0, 1'b1);
    check("t2_drop2_top", b_top, 0);
    check("t2_drop2_count", b_count, 0);
    check("t2_drop2_unf", b_unf, 0);

    // Test 3/4: five pushes into 4-entry stacks
    pulse_reset();
    push(16'd10); push(16'd11); push(16'd12); push(16'd13); push(16'd14);
    check("t3_wrap_top", w_top, 14);
    check("t3_wrap_count", w_count, 4);
    check("t3_wrap_ovf", w_ovf, 1);
    check("t3_wrap_second", w_second, 13);
    peek_index = 5'd3; #1;
    check("t3_wrap_peek3", w_peek_data, 10);
    check("t3_wrap_peek3_valid", w_peek_valid, 1);
    check("t4_rej_top", r_top, 13);
    check("t4_rej_count", r_count, 4);
    check("t4_rej_second", r_second, 12);
    check("t4_rej_ovf", r_ovf, 1);
    check("t3_big_count", b_count, 5);
    check("t3_big_ovf", b_ovf, 0);

    // clear_errors without op_valid
    step(STACK_OP_HOLD, 1'b0, 16'h0, 1'b1, 1'b0);
    check("t3_clear_wrap_ovf", w_ovf, 0);
    check("t3_clear_rej_ovf", r_ovf, 0);
    check("t3_clear_wrap_top", w_top, 14);

    // Test 5: clear and a new overflow in the same cycle; then idle cycles
    step(STACK_OP_PUSH, 1'b1, 16'd15, 1'b1, 1'b1);
    check("t5_wrap_ovf", w_ovf, 1);
    check("t5_rej_ovf", r_ovf, 1);
    check("t5_wrap_top", w_top, 15);
    check("t5_rej_top", r_top, 13);
    step(STACK_OP_PUSH, 1'b1, 16'hAA, 1'b0, 1'b0);
    step(STACK_OP_POP, 1'b1, 16'hBB, 1'b0, 1'b0);
    check("t5_idle_top", w_top, 15);
    check("t5_idle_count", w_count, 4);
    check("t5_idle_second", w_second, 14);
    check("t5_idle_ovf", w_ovf, 1);

    // Test 4: underflow on an empty stack
    pulse_reset();
    step(STACK_OP_POP, 1'b0, 16'h0, 1'b0, 1'b1);
    check("t4_rej_pop_unf", r_unf, 1);
    check("t4_rej_pop_count", r_count, 0);
    check("t4_rej_pop_top", r_top, 0);
    check("t4_wrap_pop_unf", w_unf, 1);
    check("t4_wrap_pop_count", w_count, 0);
    check("t4_wrap_pop_top", w_top, 12);
    step(STACK_OP_HOLD, 1'b0, 16'h0, 1'b1, 1'b0);
    check("t4_unf_cleared", {w_unf, r_unf}, 0);
    push(16'd7);
    step(STACK_OP_DROP2, 1'b0, 16'h0, 1'b0, 1'b1);
    check("t4_rej_drop2_unf", r_unf, 1);
    check("t4_rej_drop2_top", r_top, 7);
    check("t4_rej_drop2_count", r_count, 1);
    check("t4_wrap_drop2_top", w_top, 11);
    check("t4_wrap_drop2_count", w_count, 0);
    check("t4_wrap_drop2_unf", w_unf, 1);

    // Test 6: asynchronous reset between edges, then resume
    pulse_reset();
    push(16'd1); push(16'd2); push(16'd3);
    check("t6_pre_count", b_count, 3);
    active_low_reset = 1'b0;
    #1;
    check("t6_async_top", b_top, 0);
    check("t6_async_count", b_count, 0);
    check("t6_async_flags", {b_ovf, b_unf, w_unf, r_unf}, 0);
    active_low_reset = 1'b1;
    push(16'd9);
    check("t6_resume_top", b_top, 9);
    check("t6_resume_count", b_count, 1);
    check("t6_resume_second", b_second, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
